game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_pkg.sv | 42 ++++
 rtl/tick_prescaler.sv | 29 ++
 rtl/game_timer_ctrl.sv | 98 +++++++++
 tb/tb_game_timer_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game timing blocks: state encoding, BCD digit
// width and helpers for two-digit BCD arithmetic.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } game_state_e;

   localparam int BCD_W    = 4;
   localparam int SAT_SECS = 99;

   function automatic logic [2*BCD_W-1:0] to_bcd(input int secs);
      return {BCD_W'(secs / 10), BCD_W'(secs % 10)};
   endfunction

   // Callers never decrement 00; that value only exists in EXPIRED.
   function automatic logic [2*BCD_W-1:0] bcd_dec(input logic [2*BCD_W-1:0] v);
      if (v[BCD_W-1:0] == '0)
         return {v[2*BCD_W-1:BCD_W] - BCD_W'(1), BCD_W'(9)};
      else
         return {v[2*BCD_W-1:BCD_W], v[BCD_W-1:0] - BCD_W'(1)};
   endfunction

   function automatic logic [2*BCD_W-1:0] bcd_add10_sat(input logic [2*BCD_W-1:0] v);
      if (v[2*BCD_W-1:BCD_W] >= BCD_W'(9))
         return to_bcd(SAT_SECS);
      else
         return {v[2*BCD_W-1:BCD_W] + BCD_W'(1), v[BCD_W-1:0]};
   endfunction

   function automatic logic [2*BCD_W-1:0] bcd_clamp(input logic [2*BCD_W-1:0] v);
      logic [BCD_W-1:0] t;
      logic [BCD_W-1:0] o;
      t = (v[2*BCD_W-1:BCD_W] > BCD_W'(9)) ? BCD_W'(9) : v[2*BCD_W-1:BCD_W];
      o = (v[BCD_W-1:0] > BCD_W'(9)) ? BCD_W'(9) : v[BCD_W-1:0];
      return {t, o};
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: down-counter reloaded with TICKS_PER_SEC-1, tick on
// terminal count. Holds its phase while enable is low; zero restarts the second.
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic enable,
   input  logic zero,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   assign tick = enable && !zero && (cnt == '0);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst)
         cnt <= RELOAD;
      else if (zero)
         cnt <= RELOAD;
      else if (enable)
         cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
   end

endmodule

// File: rtl/game_timer_ctrl.sv
// Countdown game timer: BCD seconds counter with start/pause/clear/load/bonus
// controls, driven by a one-second prescaler.
//
// state   | meaning
// IDLE    | count loaded, prescaler zeroed, waiting for start
// RUN     | prescaler running, count decrements on each tick
// PAUSED  | count and prescaler phase frozen
// EXPIRED | count reached 00; only clear/load/reset leave
module game_timer_ctrl
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int START_SECS    = 60
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   input  logic             load,
   input  logic [7:0]       load_bcd,
   input  logic             bonus,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic             running,
   output logic             tick_1s,
   output logic             expired,
   output logic             done
);

   localparam logic [2*BCD_W-1:0] START_BCD = to_bcd(START_SECS);

   game_state_e state, state_nxt;
   logic [2*BCD_W-1:0] count, count_nxt;
   logic [2*BCD_W-1:0] dec_val, new_val, load_val;
   logic presc_en, presc_zero;

   assign presc_en   = (state == RUN) && !pause && !clear && !load;
   assign presc_zero = clear || load || (state == IDLE) || (state == EXPIRED);

   tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
      .clk_sys (CLOCK_50),
      .rst     (reset),
      .enable  (presc_en),
      .zero    (presc_zero),
      .tick    (tick_1s)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= START_BCD;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      expired   = 1'b0;
      load_val  = bcd_clamp(load_bcd);
      dec_val   = tick_1s ? bcd_dec(count) : count;
      // A bonus coinciding with a tick applies to the already-decremented value.
      new_val   = (bonus && state != EXPIRED) ? bcd_add10_sat(dec_val) : dec_val;

      if (clear) begin
         state_nxt = IDLE;
         count_nxt = START_BCD;
      end else if (load) begin
         count_nxt = load_val;
         state_nxt = (load_val == '0) ? EXPIRED : IDLE;
      end else begin
         count_nxt = new_val;
         unique case (state)
            IDLE:    if (start && !pause) state_nxt = RUN;
            RUN: begin
               if (pause)
                  state_nxt = PAUSED;
               else if (tick_1s && new_val == '0) begin
                  state_nxt = EXPIRED;
                  expired   = 1'b1;
               end
            end
            PAUSED:  if (start && !pause) state_nxt = RUN;
            EXPIRED: state_nxt = EXPIRED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign tens    = count[2*BCD_W-1:BCD_W];
   assign ones    = count[BCD_W-1:0];
   assign running = (state == RUN);
   assign done    = (state == EXPIRED);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with TICKS_PER_SEC=4, START_SECS=3.
module tb_game_timer_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, pause, clear, load, bonus;
   logic [7:0] load_bcd;
   logic [3:0] tens, ones;
   logic       running, tick_1s, expired, done;
   int         vectors = 0;
   int         miscompares = 0;

   game_timer_ctrl #(.TICKS_PER_SEC(4), .START_SECS(3)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .pause    (pause),
      .clear    (clear),
      .load     (load),
      .load_bcd (load_bcd),
      .bonus    (bonus),
      .tens     (tens),
      .ones     (ones),
      .running  (running),
      .tick_1s  (tick_1s),
      .expired  (expired),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [7:0] v);
      load_bcd = v;
      load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; pause = 0; clear = 0; load = 0; bonus = 0; load_bcd = 8'h00;
      cyc(); cyc();
      vectors++;
      if ({tens, ones} !== 8'h03) begin miscompares++; $display("FAIL reset_count got %h want 03", {tens, ones}); end
      vectors++;
      if ({running, tick_1s, expired, done} !== 4'b0000) begin
         miscompares++; $display("FAIL reset_flags got %b want 0000", {running, tick_1s, expired, done});
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         vectors++;
         if (tick_1s !== 1'b0 || running !== 1'b0 || {tens, ones} !== 8'h03) begin
            miscompares++; $display("FAIL idle_after_reset cyc %0d got tick=%b run=%b cnt=%h want 0 0 03", i, tick_1s, running, {tens, ones});
         end
      end
   endtask

   task automatic test_countdown();
      logic [7:0] exp_cnt;
      start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         cyc();
         exp_cnt = (c <= 4) ? 8'h03 : (c <= 8) ? 8'h02 : (c <= 12) ? 8'h01 : 8'h00;
         vectors++;
         if ({tens, ones} !== exp_cnt) begin miscompares++; $display("FAIL cd_count c%0d got %h want %h", c, {tens, ones}, exp_cnt); end
         vectors++;
         if (tick_1s !== (c == 4 || c == 8 || c == 12)) begin miscompares++; $display("FAIL cd_tick c%0d got %b", c, tick_1s); end
         vectors++;
         if (expired !== (c == 12)) begin miscompares++; $display("FAIL cd_expired c%0d got %b", c, expired); end
         vectors++;
         if (done !== (c >= 13)) begin miscompares++; $display("FAIL cd_done c%0d got %b", c, done); end
         vectors++;
         if (running !== (c <= 12)) begin miscompares++; $display("FAIL cd_running c%0d got %b", c, running); end
      end
      start = 1'b0;
      clear = 1'b1; cyc(); clear = 1'b0;
      vectors++;
      if ({done, running, tens, ones} !== {2'b00, 8'h03}) begin
         miscompares++; $display("FAIL cd_clear got done=%b run=%b cnt=%h want 0 0 03", done, running, {tens, ones});
      end
   endtask

   task automatic test_pause();
      start = 1'b1;
      cyc(); cyc(); cyc();
      pause = 1'b1; start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         vectors++;
         if (running !== 1'b0 || tick_1s !== 1'b0 || {tens, ones} !== 8'h03) begin
            miscompares++; $display("FAIL pause_hold i%0d got run=%b tick=%b cnt=%h want 0 0 03", i, running, tick_1s, {tens, ones});
         end
      end
      pause = 1'b0; start = 1'b1;
      cyc();
      vectors++;
      if (running !== 1'b1 || tick_1s !== 1'b0) begin miscompares++; $display("FAIL resume_c1 got run=%b tick=%b want 1 0", running, tick_1s); end
      cyc();
      vectors++;
      if (tick_1s !== 1'b1 || {tens, ones} !== 8'h03) begin miscompares++; $display("FAIL resume_tick got tick=%b cnt=%h want 1 03", tick_1s, {tens, ones}); end
      cyc();
      vectors++;
      if ({tens, ones} !== 8'h02) begin miscompares++; $display("FAIL resume_dec got %h want 02", {tens, ones}); end
      start = 1'b0;
      clear = 1'b1; cyc(); clear = 1'b0;
   endtask

   task automatic test_load_bonus();
      do_load(8'h10);
      vectors++;
      if ({tens, ones} !== 8'h10 || running !== 1'b0) begin miscompares++; $display("FAIL load10 got %h run=%b want 10 0", {tens, ones}, running); end
      start = 1'b1;
      cyc(); cyc(); cyc(); cyc();
      vectors++;
      if (tick_1s !== 1'b1) begin miscompares++; $display("FAIL load10_tick got %b want 1", tick_1s); end
      cyc();
      vectors++;
      if ({tens, ones} !== 8'h09) begin miscompares++; $display("FAIL borrow got %h want 09", {tens, ones}); end
      start = 1'b0;
      do_load(8'h05);
      vectors++;
      if ({tens, ones} !== 8'h05 || running !== 1'b0) begin miscompares++; $display("FAIL load05 got %h run=%b want 05 0", {tens, ones}, running); end
      start = 1'b1;
      cyc(); cyc(); cyc(); cyc();
      vectors++;
      if (tick_1s !== 1'b1) begin miscompares++; $display("FAIL load05_tick got %b want 1", tick_1s); end
      bonus = 1'b1; cyc(); bonus = 1'b0;
      vectors++;
      if ({tens, ones} !== 8'h14 || running !== 1'b1) begin miscompares++; $display("FAIL bonus_tick got %h run=%b want 14 1", {tens, ones}, running); end
      start = 1'b0;
      do_load(8'h95);
      bonus = 1'b1; cyc();
      vectors++;
      if ({tens, ones} !== 8'h99) begin miscompares++; $display("FAIL bonus_sat got %h want 99", {tens, ones}); end
      cyc(); bonus = 1'b0;
      vectors++;
      if ({tens, ones} !== 8'h99) begin miscompares++; $display("FAIL bonus_sat2 got %h want 99", {tens, ones}); end
      do_load(8'h03);
      bonus = 1'b1; cyc(); bonus = 1'b0;
      vectors++;
      if ({tens, ones} !== 8'h13) begin miscompares++; $display("FAIL bonus_idle got %h want 13", {tens, ones}); end
   endtask

   task automatic test_load_clamp();
      do_load(8'hAF);
      vectors++;
      if ({tens, ones} !== 8'h99) begin miscompares++; $display("FAIL clamp got %h want 99", {tens, ones}); end
      do_load(8'h3C);
      vectors++;
      if ({tens, ones} !== 8'h39) begin miscompares++; $display("FAIL clamp_ones got %h want 39", {tens, ones}); end
      load_bcd = 8'h00; load = 1'b1;
      #1;
      vectors++;
      if (expired !== 1'b0) begin miscompares++; $display("FAIL load00_expired_comb got %b want 0", expired); end
      cyc(); load = 1'b0;
      vectors++;
      if (done !== 1'b1 || expired !== 1'b0 || {tens, ones} !== 8'h00) begin
         miscompares++; $display("FAIL load00 got done=%b exp=%b cnt=%h want 1 0 00", done, expired, {tens, ones});
      end
      start = 1'b1; bonus = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pause = (i >= 3);
         cyc();
         vectors++;
         if ({done, expired, running, tick_1s} !== 4'b1000 || {tens, ones} !== 8'h00) begin
            miscompares++; $display("FAIL expired_sticky i%0d got d/e/r/t=%b cnt=%h want 1000 00", i, {done, expired, running, tick_1s}, {tens, ones});
         end
      end
      start = 1'b0; bonus = 1'b0; pause = 1'b0;
   endtask

   task automatic test_clear_and_reset();
      clear = 1'b1; cyc(); clear = 1'b0;
      vectors++;
      if ({tens, ones} !== 8'h03 || done !== 1'b0) begin miscompares++; $display("FAIL clear_exp got %h done=%b want 03 0", {tens, ones}, done); end
      start = 1'b1;
      cyc(); cyc(); cyc();
      clear = 1'b1; pause = 1'b1; cyc();
      clear = 1'b0; pause = 1'b0; start = 1'b0;
      vectors++;
      if (running !== 1'b0 || {tens, ones} !== 8'h03) begin
         miscompares++; $display("FAIL clear_pause got run=%b cnt=%h want 0 03", running, {tens, ones});
      end
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         vectors++;
         if (tick_1s !== (c == 4)) begin miscompares++; $display("FAIL presc_zeroed c%0d got tick=%b", c, tick_1s); end
      end
      cyc(); cyc();
      vectors++;
      if ({tens, ones} !== 8'h02 || running !== 1'b1) begin miscompares++; $display("FAIL pre_reset got %h run=%b want 02 1", {tens, ones}, running); end
      start = 1'b0;
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({tens, ones} !== 8'h03 || {running, tick_1s, expired, done} !== 4'b0000) begin
         miscompares++; $display("FAIL async_reset got cnt=%h flags=%b want 03 0000", {tens, ones}, {running, tick_1s, expired, done});
      end
      #1 reset = 1'b0;
      cyc();
      vectors++;
      if (running !== 1'b0 || {tens, ones} !== 8'h03) begin miscompares++; $display("FAIL post_reset got run=%b cnt=%h want 0 03", running, {tens, ones}); end
      start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         cyc();
         vectors++;
         if (tick_1s !== (c == 4) || {tens, ones} !== ((c <= 4) ? 8'h03 : 8'h02)) begin
            miscompares++; $display("FAIL post_reset_run c%0d got tick=%b cnt=%h", c, tick_1s, {tens, ones});
         end
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_pause();
      test_load_bonus();
      test_load_clamp();
      test_clear_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
